// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the tiny5 core datapath.
// Steps each instruction through FETCH, DECODE, EXECUTE and an optional
// memory-access state, and drives every datapath select, write enable and
// memory handshake. Datapath selects are decoded from the current state and
// the ready inputs in the same cycle, because an accepted memory access must
// write the IR, the PC or the register file on the edge that accepts it.
module multicycle_control_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic [31:0]     ir_i,
  input  logic            mem_rd_ready_i,
  input  logic            mem_wr_ready_i,
  output logic            pc_we_o,
  output logic            ir_we_o,
  output logic            regfile_we_o,
  output logic            next_pc_sel_o,
  output logic            regfile_in_sel_o,
  output logic            mem_rd_addr_sel_o,
  output logic            alu_in1_sel_o,
  output logic [1:0]      alu_in2_sel_o,
  output logic [3:0]      alu_op_o,
  output logic            mem_rd_req_o,
  output logic            mem_wr_req_o,
  output logic [2:0]      mem_size_o,
  output logic            retire_o,
  output logic            halted_o,
  output logic [XLEN-1:0] instret_o
);

  // Datapath select encodings shared with the tiny5 datapath.
  localparam logic       NEXT_PC_SEL_PC_4              = 1'b0;
  localparam logic       REGFILE_IN_SEL_ALU_OUT        = 1'b0;
  localparam logic       REGFILE_IN_SEL_MEM_RD_DATA    = 1'b1;
  localparam logic       MEM_RD_ADDR_SEL_PC            = 1'b0;
  localparam logic       MEM_RD_ADDR_SEL_ALU_OUT       = 1'b1;
  localparam logic       ALU_IN1_SEL_REGFILE_OUT1      = 1'b0;
  localparam logic [1:0] ALU_IN2_SEL_REGFILE_OUT2      = 2'd0;
  localparam logic [1:0] ALU_IN2_SEL_IR_ITYPE_IMM      = 2'd1;
  localparam logic [1:0] ALU_IN2_SEL_IR_UTYPE_IMM      = 2'd2;
  localparam logic [1:0] ALU_IN2_SEL_IR_STYPE_IMM      = 2'd3;

  localparam logic [3:0] ALU_OP_ADD             = 4'd0;
  localparam logic [3:0] ALU_OP_SUB             = 4'd1;
  localparam logic [3:0] ALU_OP_SLL             = 4'd2;
  localparam logic [3:0] ALU_OP_SLT             = 4'd3;
  localparam logic [3:0] ALU_OP_SLTU            = 4'd4;
  localparam logic [3:0] ALU_OP_XOR             = 4'd5;
  localparam logic [3:0] ALU_OP_SRL             = 4'd6;
  localparam logic [3:0] ALU_OP_SRA             = 4'd7;
  localparam logic [3:0] ALU_OP_OR              = 4'd8;
  localparam logic [3:0] ALU_OP_AND             = 4'd9;
  localparam logic [3:0] ALU_OP_IN2_PASSTHROUGH = 4'd10;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM_RD,
    S_MEM_WR,
    S_HALT
  } state_t;

  state_t     state;
  state_t     next_state;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_nz;
  logic       legal;
  logic       unused_ir;

  assign opcode    = ir_i[6:0];
  assign rd        = ir_i[11:7];
  assign funct3    = ir_i[14:12];
  assign funct7    = ir_i[31:25];
  assign rd_nz     = (rd != 5'd0);
  assign unused_ir = ^ir_i[24:15];

  // ALU operation for register and immediate arithmetic; only the register
  // form may turn ADD into SUB, both forms use funct7[5] to pick SRA.
  function automatic logic [3:0] alu_op_from_funct(input logic [2:0] f3,
                                                   input logic       alt,
                                                   input logic       allow_sub);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = (alt && allow_sub) ? ALU_OP_SUB : ALU_OP_ADD;
      F3_SLL:     op = ALU_OP_SLL;
      F3_SLT:     op = ALU_OP_SLT;
      F3_SLTU:    op = ALU_OP_SLTU;
      F3_XOR:     op = ALU_OP_XOR;
      F3_SR:      op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      F3_OR:      op = ALU_OP_OR;
      F3_AND:     op = ALU_OP_AND;
      default:    op = ALU_OP_ADD;
    endcase
    return op;
  endfunction

  // Legality of the instruction held in the IR, consulted in DECODE.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_MISC_MEM: legal = 1'b1;
      OPC_OP: legal = (funct7 == F7_ZERO) ||
                      ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
      OPC_OP_IMM: begin
        if (funct3 == F3_SLL)     legal = (funct7 == F7_ZERO);
        else if (funct3 == F3_SR) legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
        else                      legal = 1'b1;
      end
      OPC_LOAD: legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                        (funct3 == F3_LBU) || (funct3 == F3_LHU);
      OPC_STORE: legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
      default: legal = 1'b0;
    endcase
  end

  // Per-state control decode and next-state selection; every enable,
  // request and the retire pulse are forced low while reset is asserted.
  always_comb begin
    next_state        = state;
    pc_we_o           = 1'b0;
    ir_we_o           = 1'b0;
    regfile_we_o      = 1'b0;
    next_pc_sel_o     = NEXT_PC_SEL_PC_4;
    regfile_in_sel_o  = REGFILE_IN_SEL_ALU_OUT;
    mem_rd_addr_sel_o = MEM_RD_ADDR_SEL_PC;
    alu_in1_sel_o     = ALU_IN1_SEL_REGFILE_OUT1;
    alu_in2_sel_o     = ALU_IN2_SEL_REGFILE_OUT2;
    alu_op_o          = ALU_OP_ADD;
    mem_rd_req_o      = 1'b0;
    mem_wr_req_o      = 1'b0;
    mem_size_o        = 3'd0;
    retire_o          = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd_req_o      = 1'b1;
        mem_rd_addr_sel_o = MEM_RD_ADDR_SEL_PC;
        if (mem_rd_ready_i) begin
          ir_we_o    = 1'b1;
          pc_we_o    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        next_state = legal ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        next_state = S_FETCH;
        case (opcode)
          OPC_LUI: begin
            alu_in2_sel_o = ALU_IN2_SEL_IR_UTYPE_IMM;
            alu_op_o      = ALU_OP_IN2_PASSTHROUGH;
            regfile_we_o  = rd_nz;
            retire_o      = 1'b1;
          end
          OPC_OP: begin
            alu_in2_sel_o = ALU_IN2_SEL_REGFILE_OUT2;
            alu_op_o      = alu_op_from_funct(funct3, funct7[5], 1'b1);
            regfile_we_o  = rd_nz;
            retire_o      = 1'b1;
          end
          OPC_OP_IMM: begin
            alu_in2_sel_o = ALU_IN2_SEL_IR_ITYPE_IMM;
            alu_op_o      = alu_op_from_funct(funct3, funct7[5], 1'b0);
            regfile_we_o  = rd_nz;
            retire_o      = 1'b1;
          end
          OPC_LOAD: begin
            alu_in2_sel_o = ALU_IN2_SEL_IR_ITYPE_IMM;
            alu_op_o      = ALU_OP_ADD;
            next_state    = S_MEM_RD;
          end
          OPC_STORE: begin
            alu_in2_sel_o = ALU_IN2_SEL_IR_STYPE_IMM;
            alu_op_o      = ALU_OP_ADD;
            next_state    = S_MEM_WR;
          end
          OPC_MISC_MEM: begin
            retire_o = 1'b1;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        alu_in2_sel_o     = ALU_IN2_SEL_IR_ITYPE_IMM;
        alu_op_o          = ALU_OP_ADD;
        mem_rd_addr_sel_o = MEM_RD_ADDR_SEL_ALU_OUT;
        mem_size_o        = funct3;
        mem_rd_req_o      = 1'b1;
        if (mem_rd_ready_i) begin
          regfile_in_sel_o = REGFILE_IN_SEL_MEM_RD_DATA;
          regfile_we_o     = rd_nz;
          retire_o         = 1'b1;
          next_state       = S_FETCH;
        end
      end
      S_MEM_WR: begin
        alu_in2_sel_o = ALU_IN2_SEL_IR_STYPE_IMM;
        alu_op_o      = ALU_OP_ADD;
        mem_size_o    = funct3;
        mem_wr_req_o  = 1'b1;
        if (mem_wr_ready_i) begin
          retire_o   = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
    if (!reset_n_i) begin
      pc_we_o      = 1'b0;
      ir_we_o      = 1'b0;
      regfile_we_o = 1'b0;
      mem_rd_req_o = 1'b0;
      mem_wr_req_o = 1'b0;
      retire_o     = 1'b0;
    end
  end

  // State register, sticky halt flag and wrapping retired-instruction count.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state     <= S_FETCH;
      halted_o  <= 1'b0;
      instret_o <= '0;
    end else begin
      state    <= next_state;
      halted_o <= halted_o | (next_state == S_HALT);
      if (retire_o) instret_o <= instret_o + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a phase-level reference model of the
// instruction sequence, checked against the DUT every cycle, plus literal
// expectations from the hand-worked instruction scenarios.
module tb_multicycle_control_unit;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEMRD = 3, P_MEMWR = 4, P_HALT = 5;

  // ALU op codes indexed by funct3 for the non-alternate form.
  logic [3:0] op_tab [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        rd_ready = 1'b0;
  logic        wr_ready = 1'b0;

  logic        pc_we, ir_we, rf_we, npc_sel, rf_in_sel, rd_addr_sel, in1_sel;
  logic [1:0]  in2_sel;
  logic [3:0]  alu_op;
  logic        rd_req, wr_req, retire, halted;
  logic [2:0]  mem_size;
  logic [31:0] instret;

  logic        w_pc_we, w_ir_we, w_rf_we, w_npc, w_rfin, w_rda, w_in1, w_rdq, w_wrq, w_ret, w_halt;
  logic [1:0]  w_in2;
  logic [3:0]  w_op;
  logic [2:0]  w_size;
  logic [2:0]  w_instret;

  always #5 clk = ~clk;

  multicycle_control_unit #(.XLEN(32)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .ir_i(ir),
    .mem_rd_ready_i(rd_ready), .mem_wr_ready_i(wr_ready),
    .pc_we_o(pc_we), .ir_we_o(ir_we), .regfile_we_o(rf_we),
    .next_pc_sel_o(npc_sel), .regfile_in_sel_o(rf_in_sel),
    .mem_rd_addr_sel_o(rd_addr_sel), .alu_in1_sel_o(in1_sel),
    .alu_in2_sel_o(in2_sel), .alu_op_o(alu_op),
    .mem_rd_req_o(rd_req), .mem_wr_req_o(wr_req), .mem_size_o(mem_size),
    .retire_o(retire), .halted_o(halted), .instret_o(instret)
  );

  // Narrow-counter instance used to observe the instret wrap.
  multicycle_control_unit #(.XLEN(3)) dut_w (
    .clk_i(clk), .reset_n_i(reset_n), .ir_i(ir),
    .mem_rd_ready_i(rd_ready), .mem_wr_ready_i(wr_ready),
    .pc_we_o(w_pc_we), .ir_we_o(w_ir_we), .regfile_we_o(w_rf_we),
    .next_pc_sel_o(w_npc), .regfile_in_sel_o(w_rfin),
    .mem_rd_addr_sel_o(w_rda), .alu_in1_sel_o(w_in1),
    .alu_in2_sel_o(w_in2), .alu_op_o(w_op),
    .mem_rd_req_o(w_rdq), .mem_wr_req_o(w_wrq), .mem_size_o(w_size),
    .retire_o(w_ret), .halted_o(w_halt), .instret_o(w_instret)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          phase = P_FETCH;
  bit          mvalid = 0;
  logic [31:0] cur_ir = 32'h0;
  logic [31:0] count = 32'h0;
  logic [31:0] prog [$];

  // Stimulus policy.
  bit rst_req = 0;
  bit rand_mode = 0;
  bit fetch_hold = 0;
  int rd_stall_left = 0;
  int halt_cnt = 0;

  // Observed tallies for the directed scenario.
  int n_ret = 0, n_rfwe = 0, n_wrq = 0, n_rdq = 0, n_aladdr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] w);
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    if (opc == 7'h37 || opc == 7'h0F) return 1;
    if (opc == 7'h33) return (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
    if (opc == 7'h13) begin
      if (f3 == 1) return f7 == 0;
      if (f3 == 5) return f7 == 0 || f7 == 7'h20;
      return 1;
    end
    if (opc == 7'h03) return f3 != 3 && f3 != 6 && f3 != 7;
    if (opc == 7'h23) return f3 < 3;
    return 0;
  endfunction

  function automatic logic [3:0] ref_op(input logic [31:0] w, input bit reg_form);
    logic [2:0] f3 = w[14:12];
    logic [3:0] op = op_tab[f3];
    if (w[30] && f3 == 5) op = 4'd7;
    if (w[30] && f3 == 0 && reg_form) op = 4'd1;
    return op;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  f7c [3] = '{7'h00, 7'h20, 7'h00};
    f7c[2] = 7'($urandom);
    case ($urandom % 8)
      0: w[6:0] = 7'h37;
      1: begin w[6:0] = 7'h33; w[31:25] = f7c[$urandom % 3]; end
      2, 3: begin w[6:0] = 7'h13; if (w[14:12] == 1 || w[14:12] == 5) w[31:25] = f7c[$urandom % 3]; end
      4: w[6:0] = 7'h03;
      5: w[6:0] = 7'h23;
      6: w[6:0] = 7'h0F;
      default: ;
    endcase
    if ($urandom % 6 == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic run_cycle();
    logic e_pc, e_ir, e_rf, e_rfin, e_rda, e_rdq, e_wrq, e_ret;
    logic [1:0] e_in2;
    logic [3:0] e_op;
    logic [2:0] e_sz;
    logic [6:0] opc;
    bit rdnz;
    int nxt;
    @(negedge clk);
    reset_n = rst_req;
    if (rand_mode) begin
      rd_ready = ($urandom % 4) != 0;
      wr_ready = ($urandom % 4) != 0;
    end else begin
      rd_ready = 1'b1;
      wr_ready = 1'b1;
      if (phase == P_MEMRD && rd_stall_left > 0) begin rd_ready = 1'b0; rd_stall_left--; end
      if (phase == P_FETCH && fetch_hold) rd_ready = 1'b0;
    end
    if (phase == P_DECODE) ir = cur_ir;
    #1;
    {e_pc, e_ir, e_rf, e_rfin, e_rda, e_rdq, e_wrq, e_ret} = '0;
    e_in2 = 2'd0; e_op = 4'd0; e_sz = 3'd0;
    opc = cur_ir[6:0];
    rdnz = cur_ir[11:7] != 0;
    nxt = phase;
    case (phase)
      P_FETCH: begin e_rdq = 1; if (rd_ready) begin e_ir = 1; e_pc = 1; nxt = P_DECODE; end end
      P_DECODE: nxt = is_legal(cur_ir) ? P_EXEC : P_HALT;
      P_EXEC: begin
        nxt = P_FETCH;
        if (opc == 7'h37) begin e_in2 = 2; e_op = 4'd10; e_rf = rdnz; e_ret = 1; end
        else if (opc == 7'h33) begin e_op = ref_op(cur_ir, 1); e_rf = rdnz; e_ret = 1; end
        else if (opc == 7'h13) begin e_in2 = 1; e_op = ref_op(cur_ir, 0); e_rf = rdnz; e_ret = 1; end
        else if (opc == 7'h03) begin e_in2 = 1; nxt = P_MEMRD; end
        else if (opc == 7'h23) begin e_in2 = 3; nxt = P_MEMWR; end
        else e_ret = 1;
      end
      P_MEMRD: begin
        e_in2 = 1; e_rda = 1; e_sz = cur_ir[14:12]; e_rdq = 1;
        if (rd_ready) begin e_rfin = 1; e_rf = rdnz; e_ret = 1; nxt = P_FETCH; end
      end
      P_MEMWR: begin
        e_in2 = 3; e_sz = cur_ir[14:12]; e_wrq = 1;
        if (wr_ready) begin e_ret = 1; nxt = P_FETCH; end
      end
      default: ;
    endcase
    if (!reset_n) {e_pc, e_ir, e_rf, e_rdq, e_wrq, e_ret} = '0;
    chk("pc_we", pc_we, e_pc);
    chk("ir_we", ir_we, e_ir);
    chk("regfile_we", rf_we, e_rf);
    chk("mem_rd_req", rd_req, e_rdq);
    chk("mem_wr_req", wr_req, e_wrq);
    chk("retire", retire, e_ret);
    chk("req_exclusive", rd_req & wr_req, 1'b0);
    if (reset_n && mvalid) begin
      chk("next_pc_sel", npc_sel, 1'b0);
      chk("regfile_in_sel", rf_in_sel, e_rfin);
      chk("mem_rd_addr_sel", rd_addr_sel, e_rda);
      chk("alu_in1_sel", in1_sel, 1'b0);
      chk("alu_in2_sel", in2_sel, e_in2);
      chk("alu_op", alu_op, e_op);
      chk("mem_size", mem_size, e_sz);
    end
    if (mvalid) begin
      chk("halted", halted, phase == P_HALT);
      chk("instret", instret, count);
      chk("instret_wrap", w_instret, count[2:0]);
    end
    if (reset_n) begin
      n_ret += int'(retire); n_rfwe += int'(rf_we); n_wrq += int'(wr_req);
      n_rdq += int'(rd_req); n_aladdr += int'(rd_addr_sel);
    end
    if (!reset_n) begin
      phase = P_FETCH; count = 0; mvalid = 1;
    end else begin
      if (e_ir) cur_ir = (prog.size() > 0) ? prog.pop_front() : rand_instr();
      if (e_ret) count++;
      phase = nxt;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    prog.push_back(32'h00500093);  // ADDI x1,x0,5
    prog.push_back(32'h12345137);  // LUI x2,0x12345
    prog.push_back(32'h402081B3);  // SUB x3,x1,x2
    prog.push_back(32'h0080A203);  // LW x4,8(x1)
    prog.push_back(32'h0040A623);  // SW x4,12(x1)
    prog.push_back(32'h00100013);  // ADDI x0,x0,1
    prog.push_back(32'h0000006F);  // JAL
    rd_stall_left = 3;
    rst_req = 0;
    repeat (2) run_cycle();
    rst_req = 1;
    n_ret = 0; n_rfwe = 0; n_wrq = 0; n_rdq = 0; n_aladdr = 0;

    repeat (3) run_cycle();
    chk("pin_addi_in2", in2_sel, 2'd1);
    chk("pin_addi_op", alu_op, 4'd0);
    chk("pin_addi_we", rf_we, 1'b1);
    chk("pin_addi_retire", retire, 1'b1);
    after_edge();
    chk("pin_addi_instret", instret, 32'd1);

    repeat (3) run_cycle();
    chk("pin_lui_op", alu_op, 4'd10);
    chk("pin_lui_in2", in2_sel, 2'd2);
    repeat (3) run_cycle();
    chk("pin_sub_op", alu_op, 4'd1);
    chk("pin_sub_in2", in2_sel, 2'd0);
    after_edge();
    chk("pin_sub_instret", instret, 32'd3);

    repeat (7) run_cycle();
    chk("pin_lw_rfin", rf_in_sel, 1'b1);
    chk("pin_lw_we", rf_we, 1'b1);
    chk("pin_lw_size", mem_size, 3'b010);
    chk("pin_lw_addr_cycles", n_aladdr, 4);
    chk("pin_lw_rdreq_cycles", n_rdq, 8);

    repeat (4) run_cycle();
    chk("pin_sw_wrreq", wr_req, 1'b1);
    chk("pin_sw_in2", in2_sel, 2'd3);
    chk("pin_sw_size", mem_size, 3'b010);
    chk("pin_sw_wr_cycles", n_wrq, 1);

    repeat (3) run_cycle();
    chk("pin_x0_we", rf_we, 1'b0);
    chk("pin_x0_retire", retire, 1'b1);
    chk("pin_rfwe_cycles", n_rfwe, 4);
    chk("pin_retire_count", n_ret, 6);
    after_edge();
    chk("pin_total_instret", instret, 32'd6);

    // Reset arriving during a stalled fetch request.
    fetch_hold = 1;
    repeat (3) run_cycle();
    rst_req = 0;
    repeat (2) run_cycle();
    after_edge();
    chk("pin_rst_instret", instret, 32'd0);
    chk("pin_rst_halted", halted, 1'b0);
    rst_req = 1;
    fetch_hold = 0;
    run_cycle();
    chk("pin_fetch_after_rst", rd_req, 1'b1);

    // JAL halts; then reset while halted; then an illegal OP halts.
    repeat (4) run_cycle();
    chk("pin_jal_halted", halted, 1'b1);
    chk("pin_jal_instret", instret, 32'd0);
    rst_req = 0;
    run_cycle();
    after_edge();
    chk("pin_halt_rst", halted, 1'b0);
    rst_req = 1;
    prog.push_back(32'h02000033);
    repeat (5) run_cycle();
    chk("pin_add_f7_halted", halted, 1'b1);
    chk("pin_add_f7_rdreq", rd_req, 1'b0);
    rst_req = 0;
    run_cycle();

    // Randomized traffic with random stalls and occasional resets.
    rand_mode = 1;
    for (int i = 0; i < 5000; i++) begin
      rst_req = !(halt_cnt > 3 || ($urandom % 300) == 0);
      run_cycle();
      halt_cnt = (phase == P_HALT) ? halt_cnt + 1 : 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
